shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
//  Decode/issue stage directly upstream of the combinational shifter in the 16-bit CPU.
//  Accepts R-type instructions and their register operand over a valid/ready handshake.
//  Decodes the shift fields and presents them to the shifter, registered.
//  Buffers up to two instructions in a skid buffer, so neither ready path is combinational.
//  Also flags illegal encodings and counts successfully issued shift operations.
// PARAMETERS
//  DATA_W     16  operand width (shifter input Hyrja)
//  SHAMT_W     4  shift-amount field width
//  REG_ADDR_W  2  register-address field width
//  CNT_W      16  width of saturating issue counter
// PORTS
//  Clock       in   1          rising-edge clock
//  Reset_n     in   1          asynchronous, active-low reset
//  Flush       in   1          synchronous pipeline flush
//  InValid     in   1          upstream beat valid
//  InReady     out  1          stage can accept a beat
//  InInstr     in   16         instruction word
//  InRtData    in   DATA_W     rt register value, aligned with InInstr
//  OutValid    out  1          issued beat valid
//  OutReady    in   1          downstream (shifter/EX latch) accepts
//  Hyrja       out  DATA_W     operand to shifter
//  Shamt       out  SHAMT_W    shift amount
//  Funct       out  2          00=SLL, 01=SRA
//  Rd          out  REG_ADDR_W destination register
//  Illegal     out  1          beat carries an illegal encoding
//  IssueCount  out  CNT_W      legal shifts issued, saturating
// BEHAVIOUR
//  Instruction fields:
//   - [15:12] opcode; [11:10] rs; [9:8] rt; [7:6] rd; [5:2] shamt; [1:0] funct.
//   - Decode happens at input acceptance; the stored entry is {data, shamt, funct, rd, illegal}.
//  Illegal encodings:
//   - Illegal=1 when opcode!=4'b0000 or funct[1]==1.
//   - Raw fields are passed through unchanged; the beat still flows out.
//  Handshake:
//   - Accept = InValid&&InReady; issue = OutValid&&OutReady.
//   - While OutValid=1 and OutReady=0, all Out* stay stable.
//   - InValid is never required to wait for InReady.
//  States (2-bit register): EMPTY, ONE (output reg full), FULL (output + skid full).
//   - EMPTY: accept -> ONE.
//   - ONE: accept without issue -> FULL; issue without accept -> EMPTY; accept with issue -> ONE (new beat into output reg).
//   - FULL: issue -> ONE (skid moves to output reg); no accept possible.
//  Ready and latency:
//   - InReady = (state != FULL). It is a pure function of state, with no path from OutReady.
//   - Latency: a beat accepted at edge N is visible on Out* after edge N (OutValid=1 in cycle N+1).
//   - Throughput: one beat per cycle when OutReady is held at 1.
//   - Ordering is strictly FIFO; no beat is dropped or duplicated except by Flush.
//  Flush (synchronous):
//   - Next state is EMPTY; both entries are invalidated.
//   - An input beat presented in the same cycle is dropped.
//   - An issue handshake in the same cycle still completes and is counted.
//  IssueCount:
//   - Increments on issue when Illegal=0.
//   - Saturates at all-ones; never wraps.
//  Reset (asynchronous, Reset_n=0, effective immediately regardless of state):
//   - State=EMPTY, OutValid=0, InReady=1, IssueCount=0.
//   - Hyrja, Shamt, Funct, Rd and Illegal reset to 0.
//   - Deassertion is synchronised by the top level.
// STRUCTURE
//  Shared package shift_pkg:
//   - Constants: OP_RTYPE=4'b0000, FUNCT_SLL=2'b00, FUNCT_SRA=2'b01.
//   - Field bit positions.
//   - Typedef shift_entry_t {data, shamt, funct, rd, illegal}.
//   - State encoding enum.
//  Sub-module shift_skid_buffer:
//   - Generic 2-entry skid buffer over shift_entry_t.
//  Top level holds the decode logic and the saturating counter.
// TESTING
//  1. Reset: assert Reset_n=0 while FULL -> immediately OutValid=0, InReady=1, IssueCount=0, Out* fields 0.
//  2. SLL: InInstr=16'h0188, InRtData=16'd1, OutReady=1 -> next cycle OutValid=1, Hyrja=1, Shamt=2, Funct=00, Rd=2, Illegal=0; shifter yields 4; IssueCount=1.
//  3. Backpressure: OutReady=0; push A, B, C back-to-back (A=0x0188, B=0x0189, C=0x0184 as they appear in the stream).
//     -> A and B accepted; InReady=0 after B; C held. Raise OutReady -> A, B, C issue in order, one per cycle.
//  4. Illegal: 16'h018A (funct=10) and 16'h1188 (opcode=1) -> Illegal=1, beats issue, IssueCount unchanged.
//  5. Flush while FULL with InValid=1 and OutReady=1 -> head issue counted (+1); skid and input beat discarded; next cycle OutValid=0, InReady=1.
//  6. Saturation with CNT_W=4: issue 17 legal shifts -> IssueCount=4'hF, stays 4'hF.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants, field positions, entry type and state encoding
package shift_pkg;

  localparam int DATA_W     = 16;
  localparam int SHAMT_W    = 4;
  localparam int REG_ADDR_W = 2;
  localparam int INSTR_W    = 16;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [1:0] FUNCT_SLL = 2'b00;
  localparam logic [1:0] FUNCT_SRA = 2'b01;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 10;
  localparam int RT_HI    = 9;
  localparam int RT_LO    = 8;
  localparam int RD_HI    = 7;
  localparam int RD_LO    = 6;
  localparam int SHAMT_HI = 5;
  localparam int SHAMT_LO = 2;
  localparam int FUNCT_HI = 1;
  localparam int FUNCT_LO = 0;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [SHAMT_W-1:0]    shamt;
    logic [1:0]            funct;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
  } shift_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/shift_issue_stage_if.sv
// rtl/shift_issue_stage_if.sv - issue stage upstream/downstream handshake bundle
interface shift_issue_stage_if
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                  InValid;
  logic                  InReady;
  logic [INSTR_W-1:0]    InInstr;
  logic [DATA_W-1:0]     InRtData;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_W-1:0]     Hyrja;
  logic [SHAMT_W-1:0]    Shamt;
  logic [1:0]            Funct;
  logic [REG_ADDR_W-1:0] Rd;
  logic                  Illegal;
  logic [CNT_W-1:0]      IssueCount;

  modport slave (
    input  InValid, InInstr, InRtData, OutReady,
    output InReady, OutValid, Hyrja, Shamt, Funct, Rd, Illegal, IssueCount
  );

  modport master (
    output InValid, InInstr, InRtData, OutReady,
    input  InReady, OutValid, Hyrja, Shamt, Funct, Rd, Illegal, IssueCount
  );

endinterface

// File: rtl/shift_skid_buffer.sv
// rtl/shift_skid_buffer.sv - two-entry skid buffer; ready depends only on registered state
module shift_skid_buffer
  import shift_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  skid_state_t state_q;
  T            out_q;
  T            skid_q;
  logic        accept;
  logic        issue;

  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = out_q;

  // A beat presented alongside a flush is dropped; the issue side is unaffected.
  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign issue  = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q   <= in_data_i;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !issue) begin
            skid_q  <= in_data_i;
            state_q <= ST_FULL;
          end else if (accept) begin
            out_q <= in_data_i;
          end else if (issue) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (issue) begin
            out_q   <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - decodes shift instructions, buffers them and counts legal issues
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Flush,
  shift_issue_stage_if.slave  bus
);

  shift_entry_t     in_entry;
  shift_entry_t     out_entry;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             issue;

  // Illegal beats still flow through with their raw fields intact.
  always_comb begin
    in_entry.data    = bus.InRtData;
    in_entry.shamt   = bus.InInstr[SHAMT_HI:SHAMT_LO];
    in_entry.funct   = bus.InInstr[FUNCT_HI:FUNCT_LO];
    in_entry.rd      = bus.InInstr[RD_HI:RD_LO];
    in_entry.illegal = (bus.InInstr[OPC_HI:OPC_LO] != OP_RTYPE) || bus.InInstr[FUNCT_HI];
  end

  shift_skid_buffer #(
    .T (shift_entry_t)
  ) u_skid (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .flush_i     (Flush),
    .in_valid_i  (bus.InValid),
    .in_ready_o  (bus.InReady),
    .in_data_i   (in_entry),
    .out_valid_o (bus.OutValid),
    .out_ready_i (bus.OutReady),
    .out_data_o  (out_entry)
  );

  assign issue = bus.OutValid && bus.OutReady;

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !out_entry.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.Hyrja      = out_entry.data;
  assign bus.Shamt      = out_entry.shamt;
  assign bus.Funct      = out_entry.funct;
  assign bus.Rd         = out_entry.rd;
  assign bus.Illegal    = out_entry.illegal;
  assign bus.IssueCount = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - directed vector bench for shift_issue_stage
module tb_shift_issue_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_cmp;
  int   n_err;

  shift_issue_stage_if #(.CNT_W(16)) bus ();
  shift_issue_stage_if #(.CNT_W(4))  bus4 ();

  shift_issue_stage #(.CNT_W(16)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Flush   (flush),
    .bus     (bus)
  );

  shift_issue_stage #(.CNT_W(4)) dut4 (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Flush   (flush),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic [15:0] data;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_hy;
    logic [3:0]  e_sh;
    logic [1:0]  e_fn;
    logic [1:0]  e_rd;
    logic        e_il;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [15:0] instr, input logic [15:0] data,
                              input logic ordy, input logic fl, input logic e_ov, input logic e_ir,
                              input logic [15:0] e_hy, input logic [3:0] e_sh, input logic [1:0] e_fn,
                              input logic [1:0] e_rd, input logic e_il, input logic [15:0] e_cnt);
    vec_t v;
    v.iv = iv; v.instr = instr; v.data = data; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_hy = e_hy; v.e_sh = e_sh; v.e_fn = e_fn;
    v.e_rd = e_rd; v.e_il = e_il; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //            iv instr     data     rdy fl  ov ir hyrja    sh fn rd il cnt
    vecs[0]  = mk(1, 16'h0188, 16'h0001, 1, 0,  1, 1, 16'h0001, 2, 0, 2, 0, 0);
    vecs[1]  = mk(0, 16'h0000, 16'h0000, 1, 0,  0, 1, 16'h0000, 0, 0, 0, 0, 1);
    vecs[2]  = mk(1, 16'h0188, 16'h0003, 0, 0,  1, 1, 16'h0003, 2, 0, 2, 0, 1);
    vecs[3]  = mk(1, 16'h0189, 16'h8000, 0, 0,  1, 0, 16'h0003, 2, 0, 2, 0, 1);
    vecs[4]  = mk(1, 16'h0184, 16'h0005, 0, 0,  1, 0, 16'h0003, 2, 0, 2, 0, 1);
    vecs[5]  = mk(1, 16'h0184, 16'h0005, 1, 0,  1, 1, 16'h8000, 2, 1, 2, 0, 2);
    vecs[6]  = mk(1, 16'h0184, 16'h0005, 1, 0,  1, 1, 16'h0005, 1, 0, 2, 0, 3);
    vecs[7]  = mk(0, 16'h0000, 16'h0000, 1, 0,  0, 1, 16'h0000, 0, 0, 0, 0, 4);
    vecs[8]  = mk(1, 16'h018A, 16'h0007, 1, 0,  1, 1, 16'h0007, 2, 2, 2, 1, 4);
    vecs[9]  = mk(1, 16'h1188, 16'h0009, 1, 0,  1, 1, 16'h0009, 2, 0, 2, 1, 4);
    vecs[10] = mk(1, 16'h0188, 16'h0002, 1, 0,  1, 1, 16'h0002, 2, 0, 2, 0, 4);
    vecs[11] = mk(0, 16'h0000, 16'h0000, 1, 0,  0, 1, 16'h0000, 0, 0, 0, 0, 5);
    vecs[12] = mk(1, 16'h0188, 16'h0010, 0, 0,  1, 1, 16'h0010, 2, 0, 2, 0, 5);
    vecs[13] = mk(1, 16'h0189, 16'h0011, 0, 0,  1, 0, 16'h0010, 2, 0, 2, 0, 5);
    vecs[14] = mk(1, 16'h0184, 16'h0012, 1, 1,  0, 1, 16'h0000, 0, 0, 0, 0, 6);
    vecs[15] = mk(0, 16'h0000, 16'h0000, 1, 0,  0, 1, 16'h0000, 0, 0, 0, 0, 6);
    vecs[16] = mk(1, 16'h0188, 16'h0013, 0, 0,  1, 1, 16'h0013, 2, 0, 2, 0, 6);
    vecs[17] = mk(1, 16'h0189, 16'h0014, 0, 1,  0, 1, 16'h0000, 0, 0, 0, 0, 6);
    vecs[18] = mk(0, 16'h0000, 16'h0000, 0, 0,  0, 1, 16'h0000, 0, 0, 0, 0, 6);

    rst_n = 1'b0;
    flush = 1'b0;
    bus.InValid = 1'b0;  bus.InInstr = '0;  bus.InRtData = '0;  bus.OutReady = 1'b0;
    bus4.InValid = 1'b0; bus4.InInstr = '0; bus4.InRtData = '0; bus4.OutReady = 1'b0;
    #2;
    chk("rst_ov", bus.OutValid, 0);
    chk("rst_ir", bus.InReady, 1);
    chk("rst_cnt", bus.IssueCount, 0);
    chk("rst_fields", {bus.Hyrja, bus.Shamt, bus.Funct, bus.Rd, bus.Illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      bus.InValid  = vecs[i].iv;
      bus.InInstr  = vecs[i].instr;
      bus.InRtData = vecs[i].data;
      bus.OutReady = vecs[i].ordy;
      flush        = vecs[i].fl;
      step();
      chk($sformatf("v%0d_ov", i), bus.OutValid, vecs[i].e_ov);
      chk($sformatf("v%0d_ir", i), bus.InReady, vecs[i].e_ir);
      chk($sformatf("v%0d_cnt", i), bus.IssueCount, vecs[i].e_cnt);
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_fields", i), {bus.Hyrja, bus.Shamt, bus.Funct, bus.Rd, bus.Illegal},
            {vecs[i].e_hy, vecs[i].e_sh, vecs[i].e_fn, vecs[i].e_rd, vecs[i].e_il});
      end
      if (i == 0) begin
        chk("sll_result", 32'(bus.Hyrja << bus.Shamt), 32'd4);
      end
    end
    flush = 1'b0;

    // Saturation on the narrow-counter instance: 17 legal issues.
    bus4.InValid = 1'b1; bus4.InInstr = 16'h0188; bus4.InRtData = 16'h0001; bus4.OutReady = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 18) bus4.InValid = 1'b0;
      step();
      if (k == 15) chk("sat_14", bus4.IssueCount, 4'hE);
      if (k == 16) chk("sat_15", bus4.IssueCount, 4'hF);
      if (k == 18) begin
        chk("sat_17", bus4.IssueCount, 4'hF);
        chk("sat_ov", bus4.OutValid, 0);
      end
    end

    // Asynchronous reset while FULL, asserted mid-cycle.
    bus.InValid = 1'b1; bus.InInstr = 16'h0188; bus.InRtData = 16'h00AA; bus.OutReady = 1'b0;
    step();
    bus.InInstr = 16'h0189; bus.InRtData = 16'h00BB;
    step();
    chk("full_ir", bus.InReady, 0);
    chk("full_cnt", bus.IssueCount, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ov", bus.OutValid, 0);
    chk("async_ir", bus.InReady, 1);
    chk("async_cnt", bus.IssueCount, 0);
    chk("async_fields", {bus.Hyrja, bus.Shamt, bus.Funct, bus.Rd, bus.Illegal}, 0);
    chk("async_cnt4", bus4.IssueCount, 0);
    bus.InValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ov", bus.OutValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
